// File: rtl/light_pattern_monitor.sv
// Light-bar pattern monitor: decodes the four flash patterns from the
// green/red drive vectors and checks ordering and dwell timing.
module light_pattern_monitor #(
    parameter int DWELL = 12500000,
    parameter int TOL   = 1000,
    parameter int CNT_W = 26
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       clearErrors,
    input  logic [7:0] greenLight,
    input  logic [7:0] redLight,
    output logic [1:0] patternId,
    output logic       patternValid,
    output logic       changeStrobe,
    output logic       seqError,
    output logic       timingError,
    output logic [7:0] loopCount,
    output logic       locked
);

    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK} state_t;

    localparam logic [CNT_W-1:0] LO    = CNT_W'(DWELL - TOL);
    localparam logic [CNT_W-1:0] HI    = CNT_W'(DWELL + TOL);
    localparam logic [CNT_W-1:0] STALL = CNT_W'(DWELL + TOL + 1);
    localparam logic [CNT_W-1:0] MAXC  = '1;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    logic [7:0]       green1;
    logic [7:0]       red1;
    logic [CNT_W-1:0] dwell;
    logic             first;
    logic             decValid;
    logic [1:0]       decId;
    logic [1:0]       nextId;

    always_comb begin
        decValid = 1'b1;
        decId    = 2'd0;
        case ({green1, red1})
            16'h95A9: decId = 2'd0;
            16'hA995: decId = 2'd1;
            16'h9999: decId = 2'd2;
            16'hA5A5: decId = 2'd3;
            default:  decValid = 1'b0;
        endcase
    end

    assign nextId = patternId + 2'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            green1       <= 8'h00;
            red1         <= 8'h00;
            dwell        <= '0;
            first        <= 1'b0;
            patternId    <= 2'd0;
            patternValid <= 1'b0;
            changeStrobe <= 1'b0;
            seqError     <= 1'b0;
            timingError  <= 1'b0;
            loopCount    <= 8'd0;
            locked       <= 1'b0;
        end else begin
            green1       <= greenLight;
            red1         <= redLight;
            changeStrobe <= 1'b0;
            // Clear first so that an error raised below in the same cycle wins.
            if (clearErrors) begin
                seqError    <= 1'b0;
                timingError <= 1'b0;
            end
            if (!enable) begin
                state        <= IDLE;
                locked       <= 1'b0;
                patternValid <= 1'b0;
                dwell        <= '0;
                loopCount    <= 8'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= ACQUIRE;
                    end
                    ACQUIRE: begin
                        patternValid <= decValid;
                        if (decValid) begin
                            patternId    <= decId;
                            changeStrobe <= 1'b1;
                            first        <= 1'b1;
                            dwell        <= ONE;
                            locked       <= 1'b1;
                            state        <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (!decValid) begin
                            seqError     <= 1'b1;
                            patternValid <= 1'b0;
                            locked       <= 1'b0;
                            state        <= ACQUIRE;
                        end else if (decId != patternId) begin
                            changeStrobe <= 1'b1;
                            patternId    <= decId;
                            dwell        <= ONE;
                            if (decId == nextId) begin
                                if (!first && (dwell < LO || dwell > HI))
                                    timingError <= 1'b1;
                                first <= 1'b0;
                                if (patternId == 2'd3)
                                    loopCount <= loopCount + 8'd1;
                            end else begin
                                seqError <= 1'b1;
                                first    <= 1'b1;
                            end
                        end else begin
                            if (dwell == STALL)
                                timingError <= 1'b1;
                            if (dwell != MAXC)
                                dwell <= dwell + ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
